// File: rtl/csa_seq_pkg.sv
// Shared types and the carry-injection helper for the byte-serial wide adder.
// The helper is also usable by a reference model.
package csa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } csa_seq_state_t;

    localparam int BYTE_W = 8;

    // csa_8 has no carry-in, so the incoming carry is added afterwards.
    // Returns {byte_carry, byte_sum}.
    function automatic logic [BYTE_W:0] inject_carry(
        input logic [BYTE_W-1:0] sum,
        input logic              carry,
        input logic              cin
    );
        logic [BYTE_W-1:0] byte_sum;
        logic              byte_carry;
        byte_sum   = sum + BYTE_W'(cin);
        byte_carry = carry | (cin & (sum == {BYTE_W{1'b1}}));
        return {byte_carry, byte_sum};
    endfunction

endpackage

// File: rtl/csa_8.sv
// 8-bit carry-select adder: ripple low nibble, the high nibble is precomputed
// for both possible carries and selected by the low nibble carry.
module csa_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       carry
);

    logic [4:0] lo;
    logic [4:0] hi_c0;
    logic [4:0] hi_c1;
    logic [4:0] hi_sel;

    always_comb begin
        lo     = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        hi_c0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi_c1  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
        hi_sel = lo[4] ? hi_c1 : hi_c0;
        sum    = {hi_sel[3:0], lo[3:0]};
        carry  = hi_sel[4];
    end

endmodule

// File: rtl/csa_seq_add_ctrl.sv
// Byte-serial wide adder: one shared csa_8, LSB byte first, carry chained here.
//   state | meaning
//   IDLE  | ready for an operand pair
//   ADD   | one byte per cycle through csa_8
//   DONE  | result and carry_out held until the consumer takes them
module csa_seq_add_ctrl
    import csa_seq_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0]   op_a,
    input  logic [BYTE_W*NUM_BYTES-1:0]   op_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BYTE_W*NUM_BYTES-1:0]   result,
    output logic                          carry_out
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int CNT_W = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    csa_seq_state_t    state_q;
    csa_seq_state_t    state_d;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      res_q;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic [BYTE_W-1:0] csa_sum;
    logic              csa_carry;
    logic [BYTE_W:0]   inj;

    csa_8 u_csa (
        .a     (a_q[BYTE_W-1:0]),
        .b     (b_q[BYTE_W-1:0]),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    assign inj    = inject_carry(csa_sum, csa_carry, carry_q);
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = ADD;
            ADD:  if (cnt_q == LAST_BYTE) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Sum bytes enter at the top so byte 0 lands at the LSB after the last shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == ADD) begin
            a_q     <= a_q >> BYTE_W;
            b_q     <= b_q >> BYTE_W;
            res_q   <= {inj[BYTE_W-1:0], res_q[W-1:BYTE_W]};
            carry_q <= inj[BYTE_W];
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign result    = res_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_csa_seq_add_ctrl.sv
// Directed bench for csa_seq_add_ctrl with an expected-result queue.
module tb_csa_seq_add_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;

    int checks   = 0;
    int failures = 0;
    logic [W:0] sb_q[$];

    csa_seq_add_ctrl #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk({tag, "_ready_timeout"}, 64'(n), 64'(0));
    endtask

    // Accept at the next posedge, then watch for out_valid from the negedges.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit pulse);
        int n;
        logic [W:0] exp;
        wait_ready(tag);
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        sb_q.push_back({1'b0, a} + {1'b0, b});
        n = 0;
        do begin
            @(negedge clk);
            n++;
            in_valid = (pulse && n == 2);
            op_a = ~a;
            op_b = a ^ b;
            if (n == 1) chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'(0));
        end while (out_valid !== 1'b1 && n < 20);
        chk({tag, "_latency"}, 64'(n), 64'(NB + 1));
        exp = sb_q.pop_front();
        chk({tag, "_result"}, 64'(result), 64'(exp[W-1:0]));
        chk({tag, "_carry"}, 64'(carry_out), 64'(exp[W]));
        for (int h = 0; h < hold; h++) begin
            in_valid = (pulse && h == 0);
            @(negedge clk);
            in_valid = 1'b0;
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, "_hold_ready"}, 64'(in_ready), 64'(0));
            chk({tag, "_hold_result"}, {31'b0, carry_out, result}, 64'(exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_post_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_post_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_carry", 64'(carry_out), 64'(0));

        run_op("small",   32'h0000_0005, 32'h0000_0003, 0, 1'b0);
        run_op("byte_cy", 32'h0000_00FF, 32'h0000_0001, 0, 1'b0);
        run_op("ripple",  32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
        run_op("c3e8",    32'hC3C3_C3C3, 32'hE8E8_E8E8, 0, 1'b0);
        chk("c3e8_value", 64'(result), 64'hACAC_ACAB);
        run_op("bp",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b1);
        run_op("bp_next", 32'h0000_0001, 32'h0000_0001, 0, 1'b0);
        chk("bp_next_nocarry", 64'(carry_out), 64'(0));

        // Reset during the third ADD cycle discards the operation.
        wait_ready("rst_mid");
        op_a = 32'hDEAD_BEEF;
        op_b = 32'hFFFF_0001;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_result", 64'(result), 64'(0));
        chk("mid_rst_carry", 64'(carry_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NB + 2) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'(0));
        end
        run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 0, 1'b0);
        chk("after_rst_value", 64'(result), 64'h2345_6789);

        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
